// File: rtl/core_mc.sv
// Multicycle 32-register core with an N-channel req/ready peripheral bus.
// R31 is the PC; channel 0 carries instruction fetches as well as data.
module core_mc #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 13,
  parameter int N_CH    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  output logic                   mem_req,
  output logic [N_CH-1:0]        mem_sel,
  output logic [1:0]             mem_op,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [N_CH*DATA_W-1:0] mem_rdata,
  input  logic [N_CH-1:0]        mem_ready,
  output logic                   halted,
  output logic                   err,
  output logic [ADDR_W-1:0]      pc_dbg
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [2:0] {
    S_HALT,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rf [32];
  logic [31:0]       instr;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  wait_cnt;

  logic [2:0]        t;
  logic [3:0]        op;
  logic [4:0]        ra, rb, rc;
  logic [1:0]        sel, mop;
  logic [DATA_W-1:0] opa, opb, alu, pc_next, sel_rdata;
  logic [N_CH-1:0]   sel_onehot;
  logic              sel_ready, sel_legal, wb_we, timed_out;

  assign t   = instr[2:0];
  assign op  = instr[6:3];
  assign ra  = instr[11:7];
  assign rb  = instr[16:12];
  assign rc  = instr[21:17];
  assign sel = instr[6:5];
  assign mop = instr[4:3];

  assign pc_dbg    = rf[31][ADDR_W-1:0];
  assign sel_legal = int'(sel) < N_CH;
  assign timed_out = wait_cnt == CNT_W'(TIMEOUT);

  // Route the selected channel's ready/data; other channels never reach the FSM.
  always_comb begin
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    sel_onehot = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (int'(sel) == k) begin
        sel_ready     = mem_ready[k];
        sel_rdata     = mem_rdata[k*DATA_W +: DATA_W];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    opa = (t == 3'd1) ? DATA_W'(instr[31:12]) : rf[rb];
    opb = (t == 3'd2) ? DATA_W'(instr[31:17]) : rf[rc];
    case (op)
      4'd0:    alu = opa + opb;
      4'd1:    alu = opa - opb;
      4'd2:    alu = opa & opb;
      4'd3:    alu = opa | opb;
      4'd4:    alu = opa ^ opb;
      4'd5:    alu = opa << opb[SH_W-1:0];
      4'd6:    alu = opa >> opb[SH_W-1:0];
      4'd7:    alu = DATA_W'(opa < opb);
      4'd8:    alu = opa;
      4'd9:    alu = opb;
      default: alu = '0;
    endcase
  end

  // A writeback into R31 is a jump and replaces the normal increment.
  always_comb begin
    wb_we   = (t inside {3'd1, 3'd2, 3'd3}) || (t == 3'd4 && !mop[0]);
    pc_next = (wb_we && ra == 5'd31) ? wb_data : rf[31] + DATA_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HALT;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      instr     <= '0;
      wb_data   <= '0;
      wait_cnt  <= '0;
      err       <= 1'b0;
      halted    <= 1'b1;
      mem_req   <= 1'b0;
      mem_sel   <= '0;
      mem_op    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_HALT: begin
          if (ena) begin
            state    <= S_FETCH;
            halted   <= 1'b0;
            mem_req  <= 1'b1;
            mem_sel  <= N_CH'(1);
            mem_op   <= 2'd0;
            mem_addr <= rf[31][ADDR_W-1:0];
            wait_cnt <= '0;
          end
        end

        S_FETCH: begin
          if (mem_ready[0]) begin
            instr   <= mem_rdata[31:0];
            state   <= S_EXEC;
            mem_req <= 1'b0;
            mem_sel <= '0;
          end else if (timed_out) begin
            err     <= 1'b1;
            halted  <= 1'b1;
            state   <= S_HALT;
            mem_req <= 1'b0;
            mem_sel <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_EXEC: begin
          case (t)
            3'd1, 3'd2, 3'd3: begin
              wb_data <= alu;
              state   <= S_WB;
            end
            3'd4: begin
              if (!sel_legal) begin
                err    <= 1'b1;
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                state     <= S_MEM;
                mem_req   <= 1'b1;
                mem_sel   <= sel_onehot;
                mem_op    <= mop;
                mem_addr  <= rf[rb][ADDR_W-1:0];
                mem_wdata <= rf[ra];
                wait_cnt  <= '0;
              end
            end
            3'd5: begin
              for (int i = 0; i < 32; i++) rf[i] <= '0;
              halted <= 1'b1;
              state  <= S_HALT;
            end
            3'd6: begin
              if (rf[ra] != '0) begin
                rf[31]   <= rf[rb];
                state    <= S_FETCH;
                mem_req  <= 1'b1;
                mem_sel  <= N_CH'(1);
                mem_op   <= 2'd0;
                mem_addr <= rf[rb][ADDR_W-1:0];
                wait_cnt <= '0;
              end else begin
                state <= S_WB;
              end
            end
            default: state <= S_WB;
          endcase
        end

        S_MEM: begin
          if (sel_ready) begin
            if (!mop[0]) wb_data <= sel_rdata;
            state   <= S_WB;
            mem_req <= 1'b0;
            mem_sel <= '0;
            mem_op  <= 2'd0;
          end else if (timed_out) begin
            err     <= 1'b1;
            halted  <= 1'b1;
            state   <= S_HALT;
            mem_req <= 1'b0;
            mem_sel <= '0;
            mem_op  <= 2'd0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_WB: begin
          if (wb_we) rf[ra] <= wb_data;
          rf[31]   <= pc_next;
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_sel  <= N_CH'(1);
          mem_op   <= 2'd0;
          mem_addr <= pc_next[ADDR_W-1:0];
          wait_cnt <= '0;
        end

        default: begin
          state   <= S_HALT;
          halted  <= 1'b1;
          mem_req <= 1'b0;
          mem_sel <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_mc.sv
// Bench for core_mc: an instruction-level model supplies each fetched word and
// predicts every bus transaction, register writeback, PC and latency.
module tb_core_mc;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 13;
  localparam int N_CH    = 2;
  localparam int TIMEOUT = 12;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   ena = 1'b0;
  logic                   mem_req;
  logic [N_CH-1:0]        mem_sel;
  logic [1:0]             mem_op;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [N_CH*DATA_W-1:0] mem_rdata = '0;
  logic [N_CH-1:0]        mem_ready = '0;
  logic                   halted;
  logic                   err;
  logic [ADDR_W-1:0]      pc_dbg;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DATA_W-1:0] mrf [32];
  bit                merr;
  bit                mhalt;
  bit                prev_valid;
  int                prev_start;
  int                prev_lat;
  logic [DATA_W-1:0] store [int];

  core_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_CH(N_CH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .err(err), .pc_dbg(pc_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] iC20(int op, int a, int imm);
    return {20'(imm), 5'(a), 4'(op), 3'd1};
  endfunction
  function automatic logic [31:0] iC15(int op, int a, int b, int imm);
    return {15'(imm), 5'(b), 5'(a), 4'(op), 3'd2};
  endfunction
  function automatic logic [31:0] iC(int op, int a, int b, int c);
    return {10'd0, 5'(c), 5'(b), 5'(a), 4'(op), 3'd3};
  endfunction
  function automatic logic [31:0] iMem(int sel, int mop, int a, int b);
    return {15'd0, 5'(b), 5'(a), 2'(sel), 2'(mop), 3'd4};
  endfunction
  function automatic logic [31:0] iBr(int a, int b);
    return {15'd0, 5'(b), 5'(a), 4'd0, 3'd6};
  endfunction

  function automatic logic [DATA_W-1:0] aluRef(int op, logic [DATA_W-1:0] a,
                                               logic [DATA_W-1:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[5:0];
      6: return a >> b[5:0];
      7: return (a < b) ? 64'd1 : 64'd0;
      8: return a;
      9: return b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 99);
    if (r < 35)      w[2:0] = 3'($urandom_range(1, 3));
    else if (r < 55) begin w[2:0] = 3'd4; w[6:5] = 2'($urandom_range(0, N_CH - 1)); end
    else if (r < 58) begin w[2:0] = 3'd4; w[6:5] = 2'($urandom_range(N_CH, 3)); end
    else if (r < 75) w[2:0] = 3'd6;
    else if (r < 90) w[2:0] = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd7;
    else if (r < 92) w[2:0] = 3'd5;
    else             w[2:0] = 3'd3;
    return w;
  endfunction

  function automatic int randDelay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 65) return 0;
    if (r < 85) return $urandom_range(1, 3);
    if (r < 92) return $urandom_range(4, TIMEOUT - 1);
    if (r < 97) return TIMEOUT;
    return TIMEOUT + 1;
  endfunction

  task automatic driveNoise();
    mem_ready = N_CH'($urandom);
    for (int k = 0; k < N_CH; k++)
      mem_rdata[k*DATA_W +: DATA_W] = {$urandom, $urandom};
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    merr       = 0;
    mhalt      = 1;
    prev_valid = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_req",    mem_req,   0);
    checkOutput("rst_sel",    mem_sel,   0);
    checkOutput("rst_op",     mem_op,    0);
    checkOutput("rst_addr",   mem_addr,  0);
    checkOutput("rst_wdata",  mem_wdata, 0);
    checkOutput("rst_halted", halted,    1);
    checkOutput("rst_err",    err,       0);
    checkOutput("rst_pc",     pc_dbg,    0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic pulseEna();
    ena = 1'b1;
    driveNoise();
    @(negedge clk);
    ena        = 1'b0;
    mhalt      = 0;
    prev_valid = 0;
  endtask

  // One bus transaction: ready is raised on req cycle delay+1; a delay past
  // TIMEOUT means the core must abort after TIMEOUT+1 cycles.
  task automatic doBus(input int ch, input logic [1:0] e_op, input logic [ADDR_W-1:0] e_addr,
                       input logic [DATA_W-1:0] e_wdata, input bit chk_w, input int delay,
                       input logic [DATA_W-1:0] rdata, output bit aborted, output int start);
    int waited;
    logic [N_CH-1:0] e_sel;
    waited   = 0;
    e_sel    = '0;
    e_sel[ch] = 1'b1;
    aborted  = 0;
    while (mem_req !== 1'b1 && waited < 20) begin
      driveNoise();
      @(negedge clk);
      waited++;
    end
    checkOutput("bus_start", mem_req, 1);
    start = cyc;
    for (int i = 0; i <= TIMEOUT; i++) begin
      checkOutput("bus_req",  mem_req,  1);
      checkOutput("bus_sel",  mem_sel,  e_sel);
      checkOutput("bus_op",   mem_op,   e_op);
      checkOutput("bus_addr", mem_addr, e_addr);
      if (chk_w) checkOutput("bus_wdata", mem_wdata, e_wdata);
      driveNoise();
      mem_ready[ch] = (i == delay);
      mem_rdata[ch*DATA_W +: DATA_W] = rdata;
      @(negedge clk);
      if (i == delay) return;
    end
    aborted = 1;
    checkOutput("abort_req",    mem_req, 0);
    checkOutput("abort_halted", halted,  1);
    checkOutput("abort_err",    err,     1);
  endtask

  task automatic waitHalt(input string tag);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 6) begin
      driveNoise();
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_halted"}, halted, 1);
    checkOutput({tag, "_req"},    mem_req, 0);
    checkOutput({tag, "_err"},    err, merr);
    checkOutput({tag, "_pc"},     pc_dbg, mrf[31][ADDR_W-1:0]);
    mhalt      = 1;
    prev_valid = 0;
  endtask

  task automatic writeReg(input int a, input logic [DATA_W-1:0] v);
    if (a != 31) mrf[31] = mrf[31] + 1;
    mrf[a] = v;
  endtask

  // Fetch one instruction, let the model execute it, and check the DUT's bus
  // activity, PC and the previous instruction's latency against the model.
  task automatic applyStimulus(input logic [31:0] instr, input int wf, input int wm);
    logic [DATA_W-1:0] pc, opa, opb, rdv;
    logic [1:0] mop;
    int t, op, ra, rb, rc, sel, st, st2, lat, key;
    bit ab;
    pc = mrf[31];
    doBus(0, 2'b00, pc[ADDR_W-1:0], '0, 0, wf, {32'($urandom), instr}, ab, st);
    if (prev_valid) checkOutput("latency", DATA_W'(st - prev_start), DATA_W'(prev_lat));
    prev_valid = 0;
    if (ab) begin
      merr  = 1;
      mhalt = 1;
      return;
    end
    checkOutput("pc_dbg", pc_dbg, pc[ADDR_W-1:0]);
    checkOutput("run_flags", {halted, err}, {1'b0, merr});
    t   = int'(instr[2:0]);
    op  = int'(instr[6:3]);
    ra  = int'(instr[11:7]);
    rb  = int'(instr[16:12]);
    rc  = int'(instr[21:17]);
    sel = int'(instr[6:5]);
    mop = instr[4:3];
    lat = 3;
    case (t)
      1, 2, 3: begin
        opa = (t == 1) ? DATA_W'(instr[31:12]) : mrf[rb];
        opb = (t == 2) ? DATA_W'(instr[31:17]) : mrf[rc];
        writeReg(ra, aluRef(op, opa, opb));
      end
      4: begin
        if (sel >= N_CH) begin
          merr = 1;
          waitHalt("illegal");
          return;
        end
        key = sel * 8192 + int'(mrf[rb][ADDR_W-1:0]);
        rdv = store.exists(key) ? store[key] : {$urandom, $urandom};
        doBus(sel, mop, mrf[rb][ADDR_W-1:0], mrf[ra], mop[0], wm, rdv, ab, st2);
        if (ab) begin
          merr  = 1;
          mhalt = 1;
          return;
        end
        if (mop[0]) begin
          store[key] = mrf[ra];
          mrf[31]    = mrf[31] + 1;
        end else begin
          writeReg(ra, rdv);
        end
        lat = 4 + wm;
      end
      5: begin
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        waitHalt("hlt");
        return;
      end
      6: begin
        if (mrf[ra] != '0) begin
          mrf[31] = mrf[rb];
          lat     = 2;
        end else begin
          mrf[31] = mrf[31] + 1;
        end
      end
      default: mrf[31] = mrf[31] + 1;
    endcase
    prev_start = st;
    prev_lat   = lat + wf;
    prev_valid = 1;
  endtask

  initial begin
    modelReset();
    doReset();
    driveNoise();
    @(negedge clk);
    driveNoise();
    @(negedge clk);
    checkOutput("halt_hold", {halted, mem_req}, 2'b10);

    pulseEna();
    applyStimulus(iC20(8, 1, 5), 0, 0);
    applyStimulus(iC20(8, 2, 'h10), 10, 0);
    applyStimulus(iC20(8, 3, 'hDEADB), 0, 0);
    applyStimulus(iC15(5, 3, 3, 12), 0, 0);
    applyStimulus(iC15(3, 3, 3, 'hEEF), 0, 0);
    applyStimulus(iMem(0, 1, 3, 2), 0, 1);
    applyStimulus(iMem(0, 0, 4, 2), 0, 0);
    applyStimulus(iMem(1, 1, 4, 2), 0, 0);
    applyStimulus(iC20(8, 6, 1), 0, 0);
    applyStimulus(iC(1, 5, 0, 6), 0, 0);
    applyStimulus(iMem(1, 1, 5, 2), 0, 0);
    applyStimulus(iC15(5, 7, 6, 63), 0, 0);
    applyStimulus(iMem(1, 1, 7, 2), 0, 0);
    applyStimulus(iC20(8, 9, 3), 0, 0);
    applyStimulus(iC15(7, 8, 9, 7), 0, 0);
    applyStimulus(iMem(1, 1, 8, 2), 0, 0);
    applyStimulus(iC20(8, 10, 'h20), 0, 0);
    applyStimulus(iBr(6, 10), 0, 0);
    applyStimulus(iBr(0, 10), 0, 0);
    applyStimulus(iC20(8, 31, 'h40), 0, 0);
    applyStimulus(iC20(8, 11, 1), 0, 0);
    applyStimulus(iMem(1, 0, 4, 2), TIMEOUT, TIMEOUT);
    applyStimulus(iMem(1, 0, 4, 2), 0, TIMEOUT + 1);

    doReset();
    pulseEna();
    applyStimulus(iC20(8, 1, 7), 0, 0);
    applyStimulus(iMem(3, 0, 1, 2), 0, 0);
    pulseEna();
    applyStimulus(iC20(8, 1, 9), 0, 0);
    applyStimulus(32'd5, 0, 0);
    pulseEna();
    applyStimulus(iC20(8, 1, 1), 0, 0);
    applyStimulus(iC20(8, 2, 2), TIMEOUT + 1, 0);

    doReset();
    pulseEna();
    checkOutput("midrst_req_before", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_req",    mem_req, 0);
    checkOutput("midrst_halted", halted,  1);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    pulseEna();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(randInstr(), randDelay(), randDelay());
      if (mhalt) begin
        if (merr && $urandom_range(0, 1) != 0) doReset();
        pulseEna();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
